ram64x1_stream_reader: RTL and testbench

- Bit-serial read controller for a 64x1 distributed RAM (async read, negedge sync write) holding packed byte data.
- On a start command it walks the RAM address bus, samples one bit per step, assembles DATA_W-bit words LSB-first, and delivers them on a valid/ready stream.
- Sits between the RAM's address/data-out pins and a byte consumer, e.g. a PicoBlaze input port or a UART transmitter.
- Owns the RAM address bus while busy; the write side is arbitrated externally using busy.

---
 rtl/ram64x1_stream_reader.sv | 118 +++++++++++
 tb/tb_ram64x1_stream_reader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ram64x1_stream_reader.sv
// ram64x1_stream_reader: bit-serial reader that turns a 64x1 async-read RAM into a valid/ready word stream.
// Define RAM64X1_READER_SETTLE_EN to spend two cycles per bit (address settle, then sample).
module ram64x1_stream_reader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_do,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SAMPLE = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;
`ifdef RAM64X1_READER_SETTLE_EN
    localparam logic [1:0] S_SETTLE = 2'd3;
    localparam logic [1:0] S_BIT    = S_SETTLE;
`else
    localparam logic [1:0] S_BIT    = S_SAMPLE;
`endif
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d, assembled;
    logic [BW-1:0]     bit_q, bit_d;
    logic [LEN_W:0]    words_q, words_d;
    logic              valid_q, valid_d, done_q, done_d;

    always_comb begin
        assembled = shift_q;
        assembled[bit_q] = ram_do;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        data_d  = data_q;
        bit_d   = bit_q;
        words_d = words_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                addr_d  = start_addr;
                words_d = len == '0 ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
                bit_d   = '0;
                state_d = S_BIT;
            end
`ifdef RAM64X1_READER_SETTLE_EN
            S_SETTLE: state_d = S_SAMPLE;
`endif
            S_SAMPLE: begin
                shift_d = assembled;
                addr_d  = addr_q + ADDR_W'(1);
                bit_d   = bit_q + BW'(1);
                state_d = bit_q == BW'(DATA_W - 1) ? S_OUT : S_BIT;
                if (bit_q == BW'(DATA_W - 1)) begin
                    data_d  = assembled;
                    valid_d = 1'b1;
                end
            end
            S_OUT: if (out_ready) begin
                valid_d = 1'b0;
                bit_d   = '0;
                words_d = words_q > (LEN_W + 1)'(1) ? words_q - (LEN_W + 1)'(1) : words_q;
                state_d = words_q > (LEN_W + 1)'(1) ? S_BIT : S_IDLE;
                done_d  = words_q <= (LEN_W + 1)'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // abort freezes the address where it is and drops any pending word silently
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            bit_q   <= '0;
            words_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            words_q <= words_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign ram_addr  = addr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = state_q != S_IDLE;
    assign done      = done_q;
endmodule

// File: tb/tb_ram64x1_stream_reader.sv
// tb_ram64x1_stream_reader: table-driven and randomized checks of the stream reader against a bit-image model.
module tb_ram64x1_stream_reader;
`ifdef RAM64X1_READER_SETTLE_EN
    localparam int CPB = 2;
`else
    localparam int CPB = 1;
`endif
    typedef struct {
        int         sa;
        int         l;
        int         stall;
        logic [7:0] first;
        logic [7:0] last;
    } vec_t;

    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [5:0] start_addr = '0, ram_addr;
    logic [2:0] len = '0;
    logic [7:0] out_data;
    logic       out_valid, busy, done, ram_do;
    logic [63:0] ram;
    int passed = 0, total = 0;
    vec_t tbl [4];

    assign ram_do = ram[ram_addr];
    always #5 clk = ~clk;

    ram64x1_stream_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr), .len(len),
        .abort(abort), .ram_addr(ram_addr), .ram_do(ram_do), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_word(input logic [63:0] img, input int sa, input int k);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[j] = img[6'((sa + 8 * k + j) % 64)];
        return w;
    endfunction

    task automatic xfer(input int sa, input int l, input int stall, input bit restart,
                        input logic [7:0] exp_first, input logic [7:0] exp_last);
        int n;
        int cyc;
        int s;
        n = l == 0 ? 8 : l;
        start_addr = 6'(sa);
        len = 3'(l);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        for (int k = 0; k < n; k++) begin
            cyc = 0;
            while (!out_valid && cyc < 200) begin
                if (restart && k == 0 && cyc == 2) begin
                    start = 1'b1;
                    start_addr = 6'h10;
                end
                tick;
                start = 1'b0;
                cyc++;
            end
            check("latency", cyc, 8 * CPB);
            check("word", int'(out_data), int'(model_word(ram, sa, k)));
            if (k == 0) check("first_word", int'(out_data), int'(exp_first));
            if (k == n - 1) check("last_word", int'(out_data), int'(exp_last));
            s = stall < 0 ? int'($urandom_range(0, 3)) : stall;
            repeat (s) begin
                tick;
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", int'(out_data), int'(model_word(ram, sa, k)));
            end
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
            check("valid_drop", int'(out_valid), 0);
            check("done_pulse", int'(done), int'(k == n - 1));
            check("busy", int'(busy), int'(k != n - 1));
        end
        tick;
        check("done_once", int'(done), 0);
        check("final_addr", int'(ram_addr), (sa + 8 * n) % 64);
    endtask

    initial begin
        int sa;
        int l;
        int n;
        ram = 64'h0123456789ABCDEF;
        tbl[0] = '{0,     1, 0, 8'hEF, 8'hEF};
        tbl[1] = '{'h38,  2, 0, 8'h01, 8'hEF};
        tbl[2] = '{0,     0, 2, 8'hEF, 8'h01};
        tbl[3] = '{'h3C,  0, 1, 8'hF0, 8'h12};
        repeat (2) tick;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(ram_addr), 0);
        reset_n = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) xfer(tbl[i].sa, tbl[i].l, tbl[i].stall, 1'b0, tbl[i].first, tbl[i].last);
        xfer(0, 2, 0, 1'b1, 8'hEF, 8'hCD);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("idle_abort_busy", int'(busy), 0);
        start_addr = '0;
        len = 3'd2;
        out_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (8 * CPB) tick;
        check("abort_w1_valid", int'(out_valid), 1);
        tick;
        out_ready = 1'b0;
        check("abort_w1_taken", int'(out_valid), 0);
        repeat (4) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(out_valid), 0);
        check("abort_done", int'(done), 0);
        check("abort_addr", int'(ram_addr), 8 + 4 / CPB);
        tick;
        check("abort_done_later", int'(done), 0);
        check("abort_addr_hold", int'(ram_addr), 8 + 4 / CPB);
        len = 3'd1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (8 * CPB) tick;
        check("rstout_valid", int'(out_valid), 1);
        reset_n = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("rstout_valid0", int'(out_valid), 0);
        check("rstout_data", int'(out_data), 0);
        check("rstout_busy", int'(busy), 0);
        check("rstout_done", int'(done), 0);
        check("rstout_addr", int'(ram_addr), 0);
        reset_n = 1'b1;
        tick;
        for (int i = 0; i < 12; i++) begin
            ram = {$urandom, $urandom};
            sa = int'($urandom_range(0, 63));
            l = int'($urandom_range(0, 7));
            n = l == 0 ? 8 : l;
            xfer(sa, l, -1, 1'b0, model_word(ram, sa, 0), model_word(ram, sa, n - 1));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
